// File: rtl/bit_field_sequencer_pkg.sv
// Shared definitions for the bit-field sequencer: FSM state encoding and
// default widths of the word, bit index, output field and length input.
package bit_field_sequencer_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int IDX_WIDTH  = 5;
    localparam int OUT_WIDTH  = 16;
    localparam int LEN_WIDTH  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : bit_field_sequencer_pkg

// File: rtl/bit_field_sequencer.sv
// Bit-field sequencer: latches a source word, walks the external bit-select
// mux from the field MSB down to its LSB one bit per cycle, assembles the
// field MSB-first, optionally sign-extends it and offers it on a valid/ready
// output. Indices above the top of the word read as 0 and never wrap.
module bit_field_sequencer #(
    parameter int DATA_WIDTH = bit_field_sequencer_pkg::DATA_WIDTH,
    parameter int IDX_WIDTH  = bit_field_sequencer_pkg::IDX_WIDTH,
    parameter int OUT_WIDTH  = bit_field_sequencer_pkg::OUT_WIDTH,
    parameter int LEN_WIDTH  = bit_field_sequencer_pkg::LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_word,
    input  logic [IDX_WIDTH-1:0]  in_lsb,
    input  logic [LEN_WIDTH-1:0]  in_len,
    input  logic                  in_sext,
    output logic [DATA_WIDTH-1:0] mux_data,
    output logic [IDX_WIDTH-1:0]  mux_idx,
    input  logic                  mux_bit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_err
);

    import bit_field_sequencer_pkg::*;

    // The running index carries one extra bit so that positions past the
    // top of the word are recognised instead of wrapping back to bit 0.
    localparam int                   IW1       = IDX_WIDTH + 1;
    localparam logic [IDX_WIDTH:0]   IDX_LIMIT = IW1'(DATA_WIDTH);
    localparam logic [IDX_WIDTH:0]   IDX_ONE   = IW1'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO  = '0;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX   = LEN_WIDTH'(OUT_WIDTH);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   word_q;
    logic [IDX_WIDTH:0]      idx_q;
    logic [LEN_WIDTH-1:0]    cnt_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [OUT_WIDTH-1:0]    shift_q;
    logic                    sext_q;
    logic                    err_q;
    logic                    bit_in;

    // Fill the bits at and above len with the field MSB (or zeros).
    // A zero-length field has no MSB, so it always extends with zeros.
    function automatic logic [OUT_WIDTH-1:0] extend_field(
        input logic [OUT_WIDTH-1:0] field,
        input logic [LEN_WIDTH-1:0] len,
        input logic                 sext
    );
        logic                 msb;
        logic [OUT_WIDTH-1:0] res;
        msb = 1'b0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            if (len == LEN_WIDTH'(i + 1)) msb = field[i];
        end
        for (int i = 0; i < OUT_WIDTH; i++) begin
            res[i] = (LEN_WIDTH'(i) < len) ? field[i] : (sext & msb);
        end
        return res;
    endfunction

    // Out-of-range positions read as 0 regardless of what the mux returns.
    assign bit_in = (idx_q < IDX_LIMIT) ? mux_bit : 1'b0;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_err   = (state_q == ST_DONE) && err_q;
    assign out_data  = ((state_q == ST_DONE) && !err_q)
                       ? extend_field(shift_q, len_q, sext_q) : '0;
    assign mux_data  = word_q;
    assign mux_idx   = idx_q[IDX_WIDTH-1:0];

    // State register; an asynchronous reset aborts any request in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode: length checks on accept, bit count in SHIFT,
    // output handshake in DONE.
    // NOTE: state_d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_len == LEN_ZERO || in_len > LEN_MAX) state_d = ST_DONE;
                    else                                        state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LEN_ONE) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch the request on accept, then shift one bit per cycle
    // while walking the index down toward the field LSB.
    // NOTE: these are plain registers, not a memory array, so all of them
    // are cleared by reset and mux_idx is never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            shift_q <= '0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_q  <= in_word;
                        sext_q  <= in_sext;
                        shift_q <= '0;
                        idx_q   <= {1'b0, in_lsb} + IW1'(in_len) - IDX_ONE;
                        cnt_q   <= in_len;
                        len_q   <= in_len;
                        err_q   <= (in_len > LEN_MAX);
                    end
                end
                ST_SHIFT: begin
                    shift_q <= {shift_q[OUT_WIDTH-2:0], bit_in};
                    idx_q   <= idx_q - IDX_ONE;
                    cnt_q   <= cnt_q - LEN_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule : bit_field_sequencer

// File: tb/tb_bit_field_sequencer.sv
// Directed bench for bit_field_sequencer. The bench plays the role of the
// 32-bit bit-select mux, returning mux_data[mux_idx] combinationally.
module tb_bit_field_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic [4:0]  in_lsb;
    logic [4:0]  in_len;
    logic        in_sext;
    logic [31:0] mux_data;
    logic [4:0]  mux_idx;
    logic        mux_bit;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_err;

    int total;
    int bad;

    bit_field_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_lsb    (in_lsb),
        .in_len    (in_len),
        .in_sext   (in_sext),
        .mux_data  (mux_data),
        .mux_idx   (mux_idx),
        .mux_bit   (mux_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    // Bit-select mux model
    assign mux_bit = mux_data[mux_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete request: accept, wait for the result, check it, hand it off.
    task automatic run_req(input string name, input logic [31:0] word,
                           input logic [4:0] lsb, input logic [4:0] len,
                           input logic sext, input logic [15:0] exp_data,
                           input logic exp_err, input int exp_lat);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL %s ready_before: in_ready=%b want 1", name, in_ready);
        end
        in_valid = 1'b1; in_word = word; in_lsb = lsb; in_len = len; in_sext = sext;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (mux_data !== word) begin
            bad++; $display("FAIL %s mux_data: got %h want %h", name, mux_data, word);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (n !== exp_lat || out_valid !== 1'b1) begin
            bad++; $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, n, out_valid, exp_lat);
        end
        total++;
        if (out_data !== exp_data) begin
            bad++; $display("FAIL %s out_data: got %h want %h", name, out_data, exp_data);
        end
        total++;
        if (out_err !== exp_err) begin
            bad++; $display("FAIL %s out_err: got %b want %b", name, out_err, exp_err);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL %s ready_in_done: in_ready=%b want 0", name, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL %s after_handshake: valid=%b ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        total++;
        if (out_data !== 16'h0000) begin bad++; $display("FAIL reset out_data: got %h want 0000", out_data); end
        total++;
        if (out_err !== 1'b0) begin bad++; $display("FAIL reset out_err: got %b want 0", out_err); end
        total++;
        if (mux_data !== 32'h0) begin bad++; $display("FAIL reset mux_data: got %h want 0", mux_data); end
        total++;
        if (mux_idx !== 5'd0) begin bad++; $display("FAIL reset mux_idx: got %0d want 0", mux_idx); end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_extract();
        run_req("extract_ee",      32'hDEADBEEF, 5'd4,  5'd8,  1'b0, 16'h00EE, 1'b0, 8);
        run_req("extract_ee_sext", 32'hDEADBEEF, 5'd4,  5'd8,  1'b1, 16'hFFEE, 1'b0, 8);
        run_req("extract_low16",   32'hDEADBEEF, 5'd0,  5'd16, 1'b1, 16'hBEEF, 1'b0, 16);
        run_req("extract_high16",  32'hDEADBEEF, 5'd16, 5'd16, 1'b0, 16'hDEAD, 1'b0, 16);
    endtask

    task automatic test_sign_ext();
        run_req("sext_f_on",   32'h000000F0, 5'd4,  5'd4, 1'b1, 16'hFFFF, 1'b0, 4);
        run_req("sext_f_off",  32'h000000F0, 5'd4,  5'd4, 1'b0, 16'h000F, 1'b0, 4);
        run_req("sext_pos",    32'h00000070, 5'd4,  5'd4, 1'b1, 16'h0007, 1'b0, 4);
        run_req("sext_bit31",  32'hDEADBEEF, 5'd31, 5'd1, 1'b1, 16'hFFFF, 1'b0, 1);
        run_req("nosext_bit31",32'hDEADBEEF, 5'd31, 5'd1, 1'b0, 16'h0001, 1'b0, 1);
    endtask

    task automatic test_boundary();
        run_req("top_cross",      32'hA0000000, 5'd28, 5'd8,  1'b0, 16'h000A, 1'b0, 8);
        run_req("top_cross_sext", 32'hA0000000, 5'd28, 5'd8,  1'b1, 16'h000A, 1'b0, 8);
        run_req("top_cross_ones", 32'hFFFFFFFF, 5'd31, 5'd4,  1'b1, 16'h0001, 1'b0, 4);
        run_req("top_cross_16",   32'hFFFFFFFF, 5'd31, 5'd16, 1'b0, 16'h0001, 1'b0, 16);
        run_req("len_zero",       32'hFFFFFFFF, 5'd3,  5'd0,  1'b1, 16'h0000, 1'b0, 0);
        run_req("len_17",         32'hFFFFFFFF, 5'd0,  5'd17, 1'b1, 16'h0000, 1'b1, 0);
        run_req("len_31",         32'hFFFFFFFF, 5'd2,  5'd31, 1'b0, 16'h0000, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        int n;
        in_valid = 1'b1; in_word = 32'hDEADBEEF; in_lsb = 5'd0; in_len = 5'd4; in_sext = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        // A second request is offered while the first result is stalled.
        in_valid = 1'b1; in_word = 32'h12345678; in_lsb = 5'd8; in_len = 5'd8;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'h000F || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_stall[%0d]: valid=%b data=%h ready=%b want 1/000F/0", k, out_valid, out_data, in_ready);
            end
            @(posedge clk); #1;
        end
        total++;
        if (mux_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL bp_no_accept_stall: mux_data=%h want deadbeef", mux_data);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mux_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL bp_handshake_cycle: ready=%b valid=%b mux_data=%h want 1/0/deadbeef", in_ready, out_valid, mux_data);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (mux_data !== 32'h12345678) begin
            bad++; $display("FAIL bp_second_accept: mux_data=%h want 12345678", mux_data);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        total++;
        if (n !== 8 || out_data !== 16'h0056 || out_err !== 1'b0) begin
            bad++; $display("FAIL bp_second_result: lat=%0d data=%h err=%b want 8/0056/0", n, out_data, out_err);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_word = 32'hDEADBEEF; in_lsb = 5'd4; in_len = 5'd8; in_sext = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_outputs: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        total++;
        if (mux_data !== 32'h0 || mux_idx !== 5'd0) begin
            bad++; $display("FAIL midreset_regs: mux_data=%h mux_idx=%0d want 0/0", mux_data, mux_idx);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL midreset_no_result[%0d]: valid=%b want 0", k, out_valid);
            end
        end
        run_req("post_reset_f",  32'h000000F0, 5'd4, 5'd4, 1'b0, 16'h000F, 1'b0, 4);
        run_req("post_reset_ee", 32'hDEADBEEF, 5'd4, 5'd8, 1'b0, 16'h00EE, 1'b0, 8);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; in_lsb = '0; in_len = '0;
        in_sext = 1'b0; out_ready = 1'b0;
        test_reset();
        test_extract();
        test_sign_ext();
        test_boundary();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bit_field_sequencer
